// File: rtl/audio_sample_arbiter.sv
// Round-robin arbiter feeding a single audio sink from NUM_REQ sample sources,
// issuing fill words when no source has a sample and the sink is asking.
//
// state  | meaning
// S_IDLE | no word pending; grant a requester, issue a fill word, or wait
// S_PEND | word held on out_sample with out_wreq high until out_ready
module audio_sample_arbiter #(
    parameter int AUDIO_BITS = 12,
    parameter int NUM_REQ    = 2,
    parameter int FILL_MODE  = 0
) (
    input  logic                            clk,
    input  logic                            sclr,
    input  logic                            enable,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*2*AUDIO_BITS-1:0] req_sample,
    output logic [NUM_REQ-1:0]              req_ack,
    input  logic                            out_ready,
    output logic                            out_wreq,
    output logic [2*AUDIO_BITS-1:0]         out_sample,
    output logic [15:0]                     underrun_cnt,
    output logic                            busy
);

    localparam int SW    = 2 * AUDIO_BITS;
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        S_IDLE,
        S_PEND
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic             pend_fill;
    logic [SW-1:0]    last_sample;

    logic [IDX_W-1:0] rr_grant;
    logic             grant_found;
    logic [IDX_W:0]   search_sum;
    logic [IDX_W-1:0] search_idx;
    logic [SW-1:0]    grant_word;
    logic [IDX_W-1:0] rr_next;

    // Search upward from rr_ptr with wrap; the extra sum bit keeps the wrap
    // correct when NUM_REQ is not a power of two.
    always_comb begin
        grant_found = 1'b0;
        rr_grant    = rr_ptr;
        search_sum  = '0;
        search_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            search_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (search_sum >= (IDX_W+1)'(NUM_REQ)) begin
                search_sum = search_sum - (IDX_W+1)'(NUM_REQ);
            end
            search_idx = search_sum[IDX_W-1:0];
            if (!grant_found && req_valid[search_idx]) begin
                grant_found = 1'b1;
                rr_grant    = search_idx;
            end
        end
    end

    always_comb begin
        grant_word = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == rr_grant) begin
                grant_word = req_sample[k*SW +: SW];
            end
        end
    end

    assign rr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

    // out_sample doubles as the hold register for the pending word.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state        <= S_IDLE;
            out_wreq     <= 1'b0;
            out_sample   <= '0;
            req_ack      <= '0;
            busy         <= 1'b0;
            underrun_cnt <= '0;
            rr_ptr       <= '0;
            grant_idx    <= '0;
            pend_fill    <= 1'b0;
            last_sample  <= '0;
        end else begin
            req_ack <= '0;
            case (state)
                S_IDLE: begin
                    if (enable && grant_found) begin
                        state             <= S_PEND;
                        out_wreq          <= 1'b1;
                        busy              <= 1'b1;
                        out_sample        <= grant_word;
                        grant_idx         <= rr_grant;
                        pend_fill         <= 1'b0;
                        req_ack[rr_grant] <= 1'b1;
                    end else if (enable && out_ready) begin
                        state      <= S_PEND;
                        out_wreq   <= 1'b1;
                        busy       <= 1'b1;
                        out_sample <= (FILL_MODE != 0) ? '0 : last_sample;
                        pend_fill  <= 1'b1;
                        if (underrun_cnt != 16'hFFFF) begin
                            underrun_cnt <= underrun_cnt + 16'd1;
                        end
                    end
                end
                S_PEND: begin
                    if (out_ready) begin
                        state       <= S_IDLE;
                        out_wreq    <= 1'b0;
                        busy        <= 1'b0;
                        last_sample <= out_sample;
                        // fill words leave the fairness pointer alone
                        if (!pend_fill) begin
                            rr_ptr <= rr_next;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    out_wreq <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_sample_arbiter.sv
// Bench for audio_sample_arbiter: two instances (repeat-last and zero fill) on
// shared stimulus, checked each cycle against a transaction-level model.
module tb_audio_sample_arbiter;

    localparam int AB = 12;
    localparam int NR = 2;
    localparam int SW = 2 * AB;

    logic              clk = 1'b0;
    logic              sclr;
    logic              enable;
    logic              out_ready;
    logic [NR-1:0]     req_valid;
    logic [NR*SW-1:0]  req_sample;
    logic [NR-1:0]     ack0, ack1;
    logic              wreq0, wreq1;
    logic [SW-1:0]     samp0, samp1;
    logic [15:0]       cnt0, cnt1;
    logic              busy0, busy1;

    int checks = 0;
    int errors = 0;

    audio_sample_arbiter #(.AUDIO_BITS(AB), .NUM_REQ(NR), .FILL_MODE(0)) dut0 (
        .clk(clk), .sclr(sclr), .enable(enable), .req_valid(req_valid),
        .req_sample(req_sample), .req_ack(ack0), .out_ready(out_ready),
        .out_wreq(wreq0), .out_sample(samp0), .underrun_cnt(cnt0), .busy(busy0)
    );

    audio_sample_arbiter #(.AUDIO_BITS(AB), .NUM_REQ(NR), .FILL_MODE(1)) dut1 (
        .clk(clk), .sclr(sclr), .enable(enable), .req_valid(req_valid),
        .req_sample(req_sample), .req_ack(ack1), .out_ready(out_ready),
        .out_wreq(wreq1), .out_sample(samp1), .underrun_cnt(cnt1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Model: one word outstanding at a time; rules applied per rising edge.
    bit            m_live = 1'b0;
    bit            m_pend = 1'b0;
    bit            m_fill = 1'b0;
    int            m_grant = 0;
    int            m_rr = 0;
    int            m_cnt = 0;
    int            m_g;
    logic [NR-1:0] m_ack = '0;
    logic [SW-1:0] m_w0 = '0, m_w1 = '0, m_l0 = '0, m_l1 = '0;

    always @(posedge clk) begin
        if (sclr) begin
            m_live = 1'b1;
            m_pend = 1'b0;
            m_fill = 1'b0;
            m_rr   = 0;
            m_cnt  = 0;
            m_ack  = '0;
            m_w0   = '0;
            m_w1   = '0;
            m_l0   = '0;
            m_l1   = '0;
        end else if (m_pend) begin
            m_ack = '0;
            if (out_ready) begin
                m_pend = 1'b0;
                m_l0   = m_w0;
                m_l1   = m_w1;
                if (!m_fill) m_rr = (m_grant + 1) % NR;
            end
        end else if (enable) begin
            m_g = -1;
            for (int k = 0; k < NR; k++) begin
                if (m_g < 0 && ((req_valid >> ((m_rr + k) % NR)) & NR'(1)) != '0)
                    m_g = (m_rr + k) % NR;
            end
            if (m_g >= 0) begin
                m_pend  = 1'b1;
                m_fill  = 1'b0;
                m_grant = m_g;
                m_w0    = SW'(req_sample >> (m_g * SW));
                m_w1    = m_w0;
                m_ack   = NR'(1 << m_g);
            end else if (out_ready) begin
                m_pend = 1'b1;
                m_fill = 1'b1;
                m_w0   = m_l0;
                m_w1   = '0;
                if (m_cnt < 65535) m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("wreq0", 32'(wreq0), 32'(m_pend));
            chk("wreq1", 32'(wreq1), 32'(m_pend));
            chk("busy0", 32'(busy0), 32'(m_pend));
            chk("busy1", 32'(busy1), 32'(m_pend));
            chk("ack0", 32'(ack0), 32'(m_ack));
            chk("ack1", 32'(ack1), 32'(m_ack));
            chk("cnt0", 32'(cnt0), 32'(m_cnt));
            chk("cnt1", 32'(cnt1), 32'(m_cnt));
            if (m_pend) begin
                chk("sample0", 32'(samp0), 32'(m_w0));
                chk("sample1", 32'(samp1), 32'(m_w1));
            end
        end
    end

    int exp_rr[8] = '{2, 0, 1, 0, 2, 0, 1, 0};

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sclr = 1'b1; enable = 1'b0; out_ready = 1'b0; req_valid = '0; req_sample = '0;
        step(2);
        chk("rst_wreq", 32'(wreq0), 32'd0);
        chk("rst_sample", 32'(samp0), 32'd0);
        chk("rst_ack", 32'(ack0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_cnt", 32'(cnt0), 32'd0);
        sclr = 1'b0;
        step();

        // single requester
        req_sample[0 +: SW] = 24'h123456; req_valid = 2'b01; enable = 1'b1; out_ready = 1'b1;
        step();
        chk("single_ack", 32'(ack0), 32'h1);
        chk("single_wreq", 32'(wreq0), 32'h1);
        chk("single_word", 32'(samp0), 32'h123456);
        req_valid = '0; enable = 1'b0;
        step();
        chk("single_done_wreq", 32'(wreq0), 32'h0);
        chk("single_done_ack", 32'(ack0), 32'h0);

        // both valid: pointer sits at 1 after the previous word
        req_sample = {24'h222222, 24'h111111}; req_valid = 2'b11; enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_ack", 32'(ack0), 32'(exp_rr[k]));
            chk("rr_wreq", 32'(wreq0), (k % 2 == 0) ? 32'h1 : 32'h0);
            if (k % 4 == 0) chk("rr_word", 32'(samp0), 32'h222222);
            if (k % 4 == 2) chk("rr_word", 32'(samp0), 32'h111111);
        end
        req_valid = '0; enable = 1'b0;
        step();

        // underrun fill after a real word of 0xABCDEF
        req_sample[0 +: SW] = 24'hABCDEF; req_valid = 2'b01; enable = 1'b1;
        step();
        req_valid = '0; enable = 1'b0;
        step();
        enable = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("fill_wreq", 32'(wreq0), 32'h1);
            chk("fill_repeat", 32'(samp0), 32'hABCDEF);
            chk("fill_zero", 32'(samp1), 32'h0);
            step();
            chk("fill_done", 32'(wreq0), 32'h0);
        end
        enable = 1'b0;
        chk("fill_cnt0", 32'(cnt0), 32'd3);
        chk("fill_cnt1", 32'(cnt1), 32'd3);
        step(3);
        chk("disabled_idle", 32'(wreq0), 32'h0);
        chk("disabled_cnt", 32'(cnt0), 32'd3);

        // backpressure, with enable dropped mid-word
        req_sample[SW +: SW] = 24'h5A5A5A; req_valid = 2'b10; enable = 1'b1; out_ready = 1'b0;
        step();
        chk("bp_ack", 32'(ack0), 32'h2);
        req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) enable = 1'b0;
            step();
            chk("bp_wreq", 32'(wreq0), 32'h1);
            chk("bp_word", 32'(samp0), 32'h5A5A5A);
        end
        out_ready = 1'b1;
        step();
        chk("bp_done", 32'(wreq0), 32'h0);

        // reset while a word from requester 1 is pending
        req_sample[0 +: SW] = 24'h0F0F0F; req_valid = 2'b01; enable = 1'b1; out_ready = 1'b1;
        step();
        req_valid = '0; enable = 1'b0;
        step();
        req_sample[SW +: SW] = 24'h777777; req_valid = 2'b10; enable = 1'b1; out_ready = 1'b0;
        step();
        chk("mid_ack", 32'(ack0), 32'h2);
        req_valid = '0; enable = 1'b0; sclr = 1'b1; out_ready = 1'b1;
        step();
        chk("mid_rst_wreq", 32'(wreq0), 32'h0);
        chk("mid_rst_sample", 32'(samp0), 32'h0);
        chk("mid_rst_busy", 32'(busy0), 32'h0);
        chk("mid_rst_cnt", 32'(cnt0), 32'h0);
        sclr = 1'b0; enable = 1'b1;
        step();
        chk("post_rst_fill", 32'(samp0), 32'h0);
        chk("post_rst_cnt", 32'(cnt0), 32'd1);
        step();
        req_sample = {24'h333333, 24'h444444}; req_valid = 2'b11;
        step();
        chk("post_rst_grant", 32'(ack0), 32'h1);
        chk("post_rst_word", 32'(samp0), 32'h444444);
        req_valid = '0; enable = 1'b0;
        step();

        // saturation: preload near the top, then six more fills
        force dut0.underrun_cnt = 16'hFFFC;
        force dut1.underrun_cnt = 16'hFFFC;
        #1;
        release dut0.underrun_cnt;
        release dut1.underrun_cnt;
        m_cnt = 65532;
        step();
        enable = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) step(2);
        enable = 1'b0;
        chk("sat_cnt0", 32'(cnt0), 32'hFFFF);
        chk("sat_cnt1", 32'(cnt1), 32'hFFFF);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_sample_arbiter.md
AUDIO_SAMPLE_ARBITER -- requirements
Module: audio_sample_arbiter

Interface
REQ-001 Parameter AUDIO_BITS, default 12, bits per channel; the sample word is 2*AUDIO_BITS wide, left channel in the upper half.
REQ-002 Parameter NUM_REQ, default 2, number of requesters (legal range 2..4).
REQ-003 Parameter FILL_MODE, default 0, underrun fill: 0 = repeat last sample, 1 = all-zero word.
REQ-004 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 sclr  in  1  reset, synchronous, active-high.
REQ-006 enable  in  1  1 = arbitrate and fill underruns; 0 = finish any pending word, then idle.
REQ-007 req_valid  in  NUM_REQ  per-requester "sample available" level.
REQ-008 req_sample  in  NUM_REQ*2*AUDIO_BITS  per-requester sample; requester i in slice i.
REQ-009 req_ack  out  NUM_REQ  one-cycle pulse: requester's sample taken.
REQ-010 out_ready  in  1  audio sink can accept a word.
REQ-011 out_wreq  out  1  word presented to the sink.
REQ-012 out_sample  out  2*AUDIO_BITS  word presented to the sink.
REQ-013 underrun_cnt  out  16  count of fill words issued, saturating.
REQ-014 busy  out  1  high while in S_PEND.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 FSM states SHALL be S_IDLE and S_PEND; out_wreq = 1 exactly when state is S_PEND.
REQ-017 A transfer SHALL complete on a rising edge where out_wreq = 1 and out_ready = 1.
REQ-018 S_IDLE, enable = 1, any req_valid = 1: grant one requester round-robin, latch its slice into the hold register, go to S_PEND.
REQ-019 The req_ack bit of the granted requester SHALL pulse for exactly the first cycle of S_PEND; no other ack bit may be high.
REQ-020 Round-robin: search starts at index rr_ptr upward with wrap; rr_ptr SHALL become grant+1 (mod NUM_REQ) on transfer completion.
REQ-021 rr_ptr SHALL be unchanged by fill words.
REQ-022 S_IDLE, enable = 1, no req_valid, out_ready = 1 (underrun): load the fill word, go to S_PEND, increment underrun_cnt (held at 0xFFFF).
REQ-023 Fill word SHALL be last_sample when FILL_MODE = 0, else zero.
REQ-024 A pending request SHALL take precedence over underrun fill in the same cycle.
REQ-025 S_PEND: out_sample SHALL be held stable until completion.
REQ-026 On completion: last_sample SHALL load the transferred word, state SHALL return to S_IDLE, and out_wreq SHALL be 0 on the next cycle.
REQ-027 S_PEND SHALL never be aborted except by sclr; enable = 0 during S_PEND still completes the word.
REQ-028 The minimum cycle time per word is 2 cycles (grant in S_IDLE, complete in S_PEND); back-to-back S_PEND is not permitted.
REQ-029 enable = 0 in S_IDLE: no grant, no ack, no fill, underrun_cnt unchanged.
REQ-030 req_valid dropping after grant SHALL NOT affect the latched word.

Reset
REQ-031 Under sclr: state = S_IDLE, out_wreq = 0, out_sample = 0, req_ack = 0, busy = 0, underrun_cnt = 0, rr_ptr = 0, last_sample = 0, hold register = 0.
REQ-032 sclr asserted in S_PEND SHALL discard the pending word; the sink SHALL see no completion for it.
REQ-033 sclr SHALL take priority over every other input in the same cycle.

Verification
REQ-034 Single requester: req_valid[0] = 1, sample 0x123456, out_ready = 1 -> ack[0] pulses 1 cycle, out_wreq = 1 with 0x123456 for 1 cycle, then 0.
REQ-035 Both valid continuously, out_ready = 1 -> grants alternate 0,1,0,1; each ack is 1 cycle; one word every 2 cycles.
REQ-036 Underrun: FILL_MODE = 0, last word 0xABCDEF, no valid, out_ready = 1 for 3 words -> 0xABCDEF issued 3 times, underrun_cnt = 3. FILL_MODE = 1 -> 0x000000 issued.
REQ-037 Backpressure: out_ready = 0 for 10 cycles in S_PEND -> out_wreq and out_sample stay stable for 10 cycles; completes on the first cycle out_ready = 1.
REQ-038 Reset mid-word: sclr in S_PEND -> next cycle all outputs 0, no completion; the first word after release comes from requester 0.
REQ-039 Saturation: force 65540 underruns -> underrun_cnt stays 0xFFFF.
